// File: rtl/demux_pkg.sv
// Shared constants, types and the channel-select decode for the buffered 1-to-4 demultiplexer.
package demux_pkg;

  localparam int NUM_OUT = 4;
  localparam int SEL_W   = 2;
  localparam int DATA_W  = 8;

  typedef logic [SEL_W-1:0]  chan_sel_t;
  typedef logic [DATA_W-1:0] beat_t;

  function automatic logic [NUM_OUT-1:0] sel_onehot(input chan_sel_t sel);
    logic [NUM_OUT-1:0] oh;
    case (sel)
      2'd0:    oh = 4'b0001;
      2'd1:    oh = 4'b0010;
      2'd2:    oh = 4'b0100;
      2'd3:    oh = 4'b1000;
      default: oh = 4'b0000;
    endcase
    return oh;
  endfunction

endpackage

// File: rtl/chan_fifo.sv
// Per-channel FIFO: power-of-two depth, naturally wrapping pointers, head entry always visible on dout.
module chan_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             empty,
  output logic             full
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [PTR_W-1:0] wr_ptr_r;
  logic [PTR_W-1:0] rd_ptr_r;
  logic [CNT_W-1:0] count_r;
  logic             push_s;
  logic             pop_s;

  assign empty = (count_r == CNT_W'(0));
  assign full  = (count_r == CNT_W'(DEPTH));
  assign dout  = mem_r[rd_ptr_r];

  // Qualify requests: a push into a full FIFO or a pop from an empty one is ignored.
  always_comb begin
    push_s = 1'b0;
    pop_s  = 1'b0;
    if (push && !full) begin
      push_s = 1'b1;
    end else begin
      push_s = 1'b0;
    end
    if (pop && !empty) begin
      pop_s = 1'b1;
    end else begin
      pop_s = 1'b0;
    end
  end

  // Storage, pointers and occupancy; a simultaneous push and pop leaves the count unchanged.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= '0;
      end
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= '0;
    end else begin
      if (push_s) begin
        mem_r[wr_ptr_r] <= din;
        wr_ptr_r        <= wr_ptr_r + PTR_W'(1);
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_W'(1);
      end
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + CNT_W'(1);
        2'b01:   count_r <= count_r - CNT_W'(1);
        default: count_r <= count_r;
      endcase
    end
  end

endmodule

// File: rtl/demux1x4_8bit_buf.sv
// Buffered 1-to-4 demultiplexer: one valid/ready input steered by in_sel into four independent channel FIFOs.
module demux1x4_8bit_buf
  import demux_pkg::*;
#(
  parameter int WIDTH = DATA_W,
  parameter int DEPTH = 2
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [WIDTH-1:0]                in_data,
  input  logic [SEL_W-1:0]                in_sel,
  input  logic                            in_valid,
  output logic                            in_ready,
  output logic [NUM_OUT-1:0][WIDTH-1:0]   out_data,
  output logic [NUM_OUT-1:0]              out_valid,
  input  logic [NUM_OUT-1:0]              out_ready,
  output logic [7:0]                      drop_cnt
);

  logic [NUM_OUT-1:0] push_oh_s;
  logic [NUM_OUT-1:0] full_s;
  logic [NUM_OUT-1:0] empty_s;
  logic               in_ready_s;
  logic [7:0]         drop_cnt_r;

  assign in_ready  = in_ready_s;
  assign out_valid = ~empty_s;
  assign drop_cnt  = drop_cnt_r;

  // in_ready depends only on the selected channel's registered full flag, never on out_ready.
  always_comb begin
    in_ready_s = 1'b0;
    push_oh_s  = '0;
    if (full_s[in_sel]) begin
      in_ready_s = 1'b0;
    end else begin
      in_ready_s = 1'b1;
    end
    if (in_valid && in_ready_s) begin
      push_oh_s = sel_onehot(chan_sel_t'(in_sel));
    end else begin
      push_oh_s = '0;
    end
  end

  // Saturating count of stall cycles seen by the producer.
  always_ff @(posedge clk) begin
    if (rst) begin
      drop_cnt_r <= 8'd0;
    end else if (in_valid && !in_ready_s && (drop_cnt_r != 8'hFF)) begin
      drop_cnt_r <= drop_cnt_r + 8'd1;
    end else begin
      drop_cnt_r <= drop_cnt_r;
    end
  end

  for (genvar g = 0; g < NUM_OUT; g++) begin : g_chan
    chan_fifo #(
      .WIDTH (WIDTH),
      .DEPTH (DEPTH)
    ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (push_oh_s[g]),
      .din   (in_data),
      .pop   (out_ready[g]),
      .dout  (out_data[g]),
      .empty (empty_s[g]),
      .full  (full_s[g])
    );
  end

endmodule

// File: tb/tb_demux1x4_8bit_buf.sv
// Scoreboard bench for demux1x4_8bit_buf: directed stimulus queues expected beats per channel, a monitor checks pops.
module tb_demux1x4_8bit_buf;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [7:0]       in_data = 8'h00;
  logic [1:0]       in_sel = 2'd0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [3:0][7:0]  out_data;
  logic [3:0]       out_valid;
  logic [3:0]       out_ready = 4'b0000;
  logic [7:0]       drop_cnt;

  int pass_cnt = 0;
  int total_cnt = 0;
  logic [7:0] exp_q [4][$];

  demux1x4_8bit_buf #(.WIDTH(8), .DEPTH(2)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_data   (in_data),
    .in_sel    (in_sel),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .drop_cnt  (drop_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) begin
      pass_cnt++;
    end else begin
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // One cycle: drive just after the rising edge, check in_ready at the falling edge.
  // er: 1 = expect accept (beat queued), 0 = expect stall, -1 = no check.
  task automatic cyc(input logic r, input logic v, input logic [1:0] s, input logic [7:0] d,
                     input logic [3:0] ordy, input int er);
    @(posedge clk);
    #1;
    rst = r; in_valid = v; in_sel = s; in_data = d; out_ready = ordy;
    @(negedge clk);
    if (er >= 0) begin
      chk("in_ready", 32'(in_ready), 32'(er[0]));
      if (er == 1) exp_q[s].push_back(d);
    end
  endtask

  // Monitor: every handshake on an output channel must match the head of that channel's queue.
  always @(negedge clk) begin
    if (rst) begin
      for (int i = 0; i < 4; i++) exp_q[i].delete();
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (out_valid[i] && out_ready[i]) begin
          if (exp_q[i].size() == 0) begin
            total_cnt++;
            $display("FAIL pop_ch%0d: got %0h expected no beat", i, out_data[i]);
          end else begin
            chk($sformatf("pop_ch%0d", i), 32'(out_data[i]), 32'(exp_q[i].pop_front()));
          end
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    int exp_d;
    // Reset state
    cyc(1'b1, 1'b0, 2'd0, 8'h00, 4'b0000, -1);
    cyc(1'b1, 1'b0, 2'd0, 8'h00, 4'b0000, -1);
    cyc(1'b0, 1'b0, 2'd0, 8'h00, 4'b0000, -1);
    chk("rst_out_valid", 32'(out_valid), 32'h0);
    chk("rst_drop_cnt", 32'(drop_cnt), 32'h0);
    chk("rst_out_data", 32'(out_data), 32'h0);
    for (int s = 0; s < 4; s++) begin
      in_sel = 2'(s);
      #1;
      chk($sformatf("rst_in_ready_sel%0d", s), 32'(in_ready), 32'h1);
    end

    // Single beat to channel 2
    cyc(1'b0, 1'b1, 2'd2, 8'hA5, 4'b0000, 1);
    cyc(1'b0, 1'b0, 2'd0, 8'h00, 4'b0000, -1);
    chk("single_out_valid", 32'(out_valid), 32'h4);
    chk("single_out_data2", 32'(out_data[2]), 32'hA5);
    cyc(1'b0, 1'b0, 2'd0, 8'h00, 4'b0100, -1);
    cyc(1'b0, 1'b0, 2'd0, 8'h00, 4'b0000, -1);
    chk("single_drained", 32'(out_valid), 32'h0);

    // Fill channel 1, backpressure, other channel still accepted
    cyc(1'b0, 1'b1, 2'd1, 8'h11, 4'b0000, 1);
    cyc(1'b0, 1'b1, 2'd1, 8'h22, 4'b0000, 1);
    cyc(1'b0, 1'b1, 2'd1, 8'h33, 4'b0000, 0);
    chk("fill_drop0", 32'(drop_cnt), 32'h0);
    cyc(1'b0, 1'b1, 2'd1, 8'h33, 4'b0000, 0);
    chk("fill_drop1", 32'(drop_cnt), 32'h1);
    cyc(1'b0, 1'b1, 2'd3, 8'h44, 4'b0000, 1);
    chk("fill_drop2", 32'(drop_cnt), 32'h2);
    chk("fill_out_valid", 32'(out_valid), 32'h2);
    cyc(1'b0, 1'b1, 2'd1, 8'h33, 4'b0010, 0);
    chk("fill_no_bypass_valid", 32'(out_valid), 32'hA);
    cyc(1'b0, 1'b1, 2'd1, 8'h33, 4'b0000, 1);
    chk("fill_drop3", 32'(drop_cnt), 32'h3);
    repeat (3) cyc(1'b0, 1'b0, 2'd0, 8'h00, 4'b1111, -1);
    chk("fill_drained", 32'(out_valid), 32'h0);
    chk("fill_drop_hold", 32'(drop_cnt), 32'h3);

    // Order and pointer wrap on channel 0, one beat per cycle
    for (int k = 1; k <= 8; k++) begin
      cyc(1'b0, 1'b1, 2'd0, 8'(k), 4'b0001, 1);
      if (k >= 2) chk($sformatf("stream_valid_%0d", k), 32'(out_valid[0]), 32'h1);
    end
    cyc(1'b0, 1'b0, 2'd0, 8'h00, 4'b0001, -1);
    cyc(1'b0, 1'b0, 2'd0, 8'h00, 4'b0000, -1);
    chk("stream_drained", 32'(out_valid), 32'h0);

    // Simultaneous push/pop on channel 0 with pops on channels 1 and 2
    cyc(1'b0, 1'b1, 2'd1, 8'hAA, 4'b0000, 1);
    cyc(1'b0, 1'b1, 2'd2, 8'hBB, 4'b0000, 1);
    cyc(1'b0, 1'b1, 2'd0, 8'hC0, 4'b0000, 1);
    cyc(1'b0, 1'b1, 2'd0, 8'hC1, 4'b1111, 1);
    cyc(1'b0, 1'b0, 2'd0, 8'h00, 4'b0000, -1);
    chk("simul_out_valid", 32'(out_valid), 32'h1);
    chk("simul_out_data0", 32'(out_data[0]), 32'hC1);
    cyc(1'b0, 1'b0, 2'd0, 8'h00, 4'b0001, -1);
    cyc(1'b0, 1'b0, 2'd0, 8'h00, 4'b0000, -1);
    chk("simul_drained", 32'(out_valid), 32'h0);

    // Reset mid-operation with channels 0 and 3 full
    cyc(1'b0, 1'b1, 2'd0, 8'hE0, 4'b0000, 1);
    cyc(1'b0, 1'b1, 2'd0, 8'hE1, 4'b0000, 1);
    cyc(1'b0, 1'b1, 2'd3, 8'hF0, 4'b0000, 1);
    cyc(1'b0, 1'b1, 2'd3, 8'hF1, 4'b0000, 1);
    cyc(1'b0, 1'b1, 2'd0, 8'hE2, 4'b0000, 0);
    chk("midrst_pre_valid", 32'(out_valid), 32'h9);
    cyc(1'b1, 1'b1, 2'd1, 8'h5A, 4'b1111, -1);
    cyc(1'b0, 1'b0, 2'd1, 8'h00, 4'b0000, -1);
    chk("midrst_out_valid", 32'(out_valid), 32'h0);
    chk("midrst_drop_cnt", 32'(drop_cnt), 32'h0);
    chk("midrst_in_ready1", 32'(in_ready), 32'h1);
    in_sel = 2'd0;
    #1;
    chk("midrst_in_ready0", 32'(in_ready), 32'h1);

    // drop_cnt saturation on a full channel 2
    cyc(1'b0, 1'b1, 2'd2, 8'hD0, 4'b0000, 1);
    cyc(1'b0, 1'b1, 2'd2, 8'hD1, 4'b0000, 1);
    for (int k = 1; k <= 300; k++) begin
      cyc(1'b0, 1'b1, 2'd2, 8'hD2, 4'b0000, 0);
      exp_d = (k - 1 > 255) ? 255 : k - 1;
      chk($sformatf("sat_drop_%0d", k), 32'(drop_cnt), 32'(exp_d));
    end
    cyc(1'b0, 1'b0, 2'd0, 8'h00, 4'b0100, -1);
    chk("sat_hold", 32'(drop_cnt), 32'hFF);
    cyc(1'b0, 1'b0, 2'd0, 8'h00, 4'b0100, -1);
    cyc(1'b0, 1'b0, 2'd0, 8'h00, 4'b0000, -1);
    chk("sat_drained", 32'(out_valid), 32'h0);
    chk("sat_final", 32'(drop_cnt), 32'hFF);

    for (int i = 0; i < 4; i++) begin
      chk($sformatf("queue_empty_ch%0d", i), 32'(exp_q[i].size()), 32'h0);
    end

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
